// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: address geometry, reset vector and
// the control-flow redirect kinds resolved by the fetch unit.
package cpu_pkg;

    localparam int                ADDR_W    = 16;
    localparam int                IMM_W     = 10;
    localparam logic [ADDR_W-1:0] RESET_VEC = 16'h0000;

    typedef enum logic [2:0] {
        NONE,
        BRX,
        JMP,
        CALL,
        RET
    } redirect_e;

endpackage

// File: rtl/return_stack.sv
// Circular hardware return-address stack. Overflow overwrites the oldest entry,
// underflow returns whatever the pointer lands on; both raise sticky flags.
module return_stack
#(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_idx;

    // ptr names the next free slot; the top of stack sits just below it.
    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (pop) begin
            ptr <= top_idx;
            if (count == '0) underflow <= 1'b1;
            else             count     <= count - (PW+1)'(1);
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (count == CNT_FULL) overflow <= 1'b1;
            else                   count    <= count + (PW+1)'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointer define validity.
    always_ff @(posedge clk) begin
        if (!rst && push && !pop) mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter and fetch control: tracks fetch/decode/execute addresses,
// resolves ret/jmp/call/branch redirects and issues decoder flushes.
module pc_unit
#(
    parameter int                ADDR_W    = cpu_pkg::ADDR_W,
    parameter int                RS_DEPTH  = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = cpu_pkg::RESET_VEC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard,
    input  logic              p_cache_miss,
    input  logic              pc_jmp,
    input  logic              pc_call,
    input  logic              pc_ret,
    input  logic              pc_brx,
    input  logic              pc_brxt,
    input  logic              brx_cond,
    input  logic [9:0]        I_field,
    input  logic [ADDR_W-1:0] long_target,
    input  logic              long_sel,
    output logic [ADDR_W-1:0] prg_addr,
    output logic              input_flush,
    output logic              output_flush,
    output logic              jmp_rst,
    output logic              brx_rst,
    output logic              rs_overflow,
    output logic              rs_underflow
);

    import cpu_pkg::*;

    localparam int SP_W = $clog2(RS_DEPTH);

    logic [ADDR_W-1:0] pc_f1, pc_dec, pc_exe;
    logic [ADDR_W-1:0] target, jmp_target, brx_target, rs_top;
    logic [SP_W:0]     rs_count;
    redirect_e         kind;
    logic              redirect, advance;

    // Priority ret > jmp/call > brx only matters for illegal strobe overlap.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        kind = NONE;
        if (pc_ret)                                 kind = RET;
        else if (pc_call)                           kind = CALL;
        else if (pc_jmp)                            kind = JMP;
        else if (pc_brx && (brx_cond == pc_brxt))   kind = BRX;
    end

    assign jmp_target = long_sel ? long_target : {pc_exe[ADDR_W-1:IMM_W], I_field};
    assign brx_target = pc_exe + {{(ADDR_W-IMM_W){I_field[IMM_W-1]}}, I_field};

    always_comb begin
        target = prg_addr;
        case (kind)
            RET:       target = rs_top;
            JMP, CALL: target = jmp_target;
            BRX:       target = brx_target;
            default:   target = prg_addr;
        endcase
    end

    assign redirect     = !rst && (kind != NONE);
    assign advance      = !hazard && !p_cache_miss;
    assign input_flush  = redirect;
    assign output_flush = redirect;
    assign jmp_rst      = !rst && (pc_jmp || pc_call);
    assign brx_rst      = !rst && pc_brx;

    // Redirects win over stalls: the whole tracking pipeline restarts at target.
    always_ff @(posedge clk) begin
        if (rst) begin
            prg_addr <= RESET_VEC;
            pc_f1    <= RESET_VEC;
            pc_dec   <= RESET_VEC;
            pc_exe   <= RESET_VEC;
        end else if (redirect) begin
            prg_addr <= target;
            pc_f1    <= target;
            pc_dec   <= target;
            pc_exe   <= target;
        end else if (advance) begin
            prg_addr <= prg_addr + ADDR_W'(1);
            pc_f1    <= prg_addr;
            pc_dec   <= pc_f1;
            pc_exe   <= pc_dec;
        end
    end

    return_stack #(
        .DEPTH (RS_DEPTH),
        .W     (ADDR_W)
    ) u_return_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (kind == CALL),
        .pop       (kind == RET),
        .push_data (pc_exe + ADDR_W'(1)),
        .top       (rs_top),
        .count     (rs_count),
        .overflow  (rs_overflow),
        .underflow (rs_underflow)
    );

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        rs_count <= (SP_W+1)'(RS_DEPTH));

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded bench for pc_unit: a reference model predicts each cycle's
// strobes and next prg_addr/flags; scenario tasks add fixed-value checks.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0, p_cache_miss = 1'b0;
    logic        pc_jmp = 1'b0, pc_call = 1'b0, pc_ret = 1'b0;
    logic        pc_brx = 1'b0, pc_brxt = 1'b0, brx_cond = 1'b0;
    logic [9:0]  I_field = '0;
    logic [15:0] long_target = '0;
    logic        long_sel = 1'b0;
    logic [15:0] prg_addr;
    logic        input_flush, output_flush, jmp_rst, brx_rst;
    logic        rs_overflow, rs_underflow;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .p_cache_miss (p_cache_miss),
        .pc_jmp       (pc_jmp),
        .pc_call      (pc_call),
        .pc_ret       (pc_ret),
        .pc_brx       (pc_brx),
        .pc_brxt      (pc_brxt),
        .brx_cond     (brx_cond),
        .I_field      (I_field),
        .long_target  (long_target),
        .long_sel     (long_sel),
        .prg_addr     (prg_addr),
        .input_flush  (input_flush),
        .output_flush (output_flush),
        .jmp_rst      (jmp_rst),
        .brx_rst      (brx_rst),
        .rs_overflow  (rs_overflow),
        .rs_underflow (rs_underflow)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic        ovf;
        logic        unf;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state
    logic [15:0] m_addr, m_f1, m_dec, m_exe;
    logic [15:0] m_rs [16];
    int          m_ptr, m_cnt;
    logic        m_ovf, m_unf;

    // Combinational outputs sampled during the most recent step
    logic obs_if, obs_of, obs_jr, obs_br;

    task automatic step(input logic r, input logic hz, input logic miss,
                        input logic jmp, input logic call, input logic ret,
                        input logic brx, input logic brxt, input logic cond,
                        input logic [9:0] imm, input logic [15:0] lt, input logic ls);
        logic        redir, e_jr, e_br;
        logic [15:0] tgt;
        exp_t        e, got;
        @(negedge clk);
        rst = r; hazard = hz; p_cache_miss = miss;
        pc_jmp = jmp; pc_call = call; pc_ret = ret;
        pc_brx = brx; pc_brxt = brxt; brx_cond = cond;
        I_field = imm; long_target = lt; long_sel = ls;

        redir = !r && (ret || jmp || call || (brx && (cond == brxt)));
        if (ret)               tgt = m_rs[(m_ptr + 15) % 16];
        else if (jmp || call)  tgt = ls ? lt : {m_exe[15:10], imm};
        else                   tgt = m_exe + {{6{imm[9]}}, imm};
        e_jr = !r && (jmp || call);
        e_br = !r && brx;

        #1;
        obs_if = input_flush; obs_of = output_flush; obs_jr = jmp_rst; obs_br = brx_rst;
        tests_run++;
        if ({input_flush, output_flush, jmp_rst, brx_rst} !== {redir, redir, e_jr, e_br}) begin
            tests_failed++;
            $display("FAIL strobes @%0t: got if/of/jr/br=%b%b%b%b expected %b%b%b%b",
                     $time, input_flush, output_flush, jmp_rst, brx_rst, redir, redir, e_jr, e_br);
        end

        if (r) begin
            m_addr = 16'h0000; m_f1 = 16'h0000; m_dec = 16'h0000; m_exe = 16'h0000;
            m_ptr = 0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (ret) begin
                if (m_cnt == 0) m_unf = 1'b1; else m_cnt--;
                m_ptr = (m_ptr + 15) % 16;
            end else if (call) begin
                m_rs[m_ptr] = m_exe + 16'd1;
                m_ptr = (m_ptr + 1) % 16;
                if (m_cnt == 16) m_ovf = 1'b1; else m_cnt++;
            end
            if (redir) begin
                m_addr = tgt; m_f1 = tgt; m_dec = tgt; m_exe = tgt;
            end else if (!hz && !miss) begin
                m_exe = m_dec; m_dec = m_f1; m_f1 = m_addr; m_addr = m_addr + 16'd1;
            end
        end
        e = '{addr: m_addr, ovf: m_ovf, unf: m_unf};
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e   = sb_q.pop_front();
            got = '{addr: prg_addr, ovf: rs_overflow, unf: rs_underflow};
            if (got !== e) begin
                tests_failed++;
                $display("FAIL state @%0t: got addr=%h ovf=%b unf=%b expected addr=%h ovf=%b unf=%b",
                         $time, got.addr, got.ovf, got.unf, e.addr, e.ovf, e.unf);
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 0);
    endtask

    task automatic long_jmp(input logic [15:0] t);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 10'h000, t, 1);
    endtask

    task automatic expect16(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect1(input string name, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 0);
    endtask

    task automatic test_reset();
        do_reset();
        expect16("reset_addr", prg_addr, 16'h0000);
        expect1("reset_ovf", rs_overflow, 1'b0);
        expect1("reset_unf", rs_underflow, 1'b0);
        expect1("reset_flush", obs_if | obs_of | obs_jr | obs_br, 1'b0);
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            idle();
            expect16("free_run_addr", prg_addr, 16'(i));
            expect1("free_run_flush", obs_if | obs_of, 1'b0);
        end
    endtask

    task automatic test_cache_miss();
        do_reset();
        for (int i = 0; i < 4; i++) idle();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 0);
            expect16("miss_hold", prg_addr, 16'h0004);
        end
        idle();
        expect16("miss_resume", prg_addr, 16'h0005);
    endtask

    task automatic test_branch();
        do_reset();
        long_jmp(16'h0010);
        expect16("jmp_to_0010", prg_addr, 16'h0010);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 10'h3FE, 16'h0000, 0);
        expect1("brx_taken_rst", obs_br, 1'b1);
        expect1("brx_taken_flush", obs_if & obs_of, 1'b1);
        expect16("brx_taken_addr", prg_addr, 16'h000E);
        long_jmp(16'h0010);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 10'h3FE, 16'h0000, 0);
        expect1("brx_not_taken_rst", obs_br, 1'b1);
        expect1("brx_not_taken_flush", obs_if | obs_of, 1'b0);
        expect16("brx_not_taken_addr", prg_addr, 16'h0011);
    endtask

    task automatic test_call_ret();
        do_reset();
        long_jmp(16'h0420);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 10'h055, 16'h0000, 0);
        expect1("call_jmp_rst", obs_jr, 1'b1);
        expect16("call_addr", prg_addr, 16'h0455);
        for (int i = 0; i < 3; i++) idle();
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 10'h000, 16'h0000, 0);
        expect1("ret_flush", obs_if, 1'b1);
        expect16("ret_addr", prg_addr, 16'h0421);
        long_jmp(16'hFFFF);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 10'h000, 16'h2000, 1);
        expect16("long_call_addr", prg_addr, 16'h2000);
        idle();
        idle();
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 10'h000, 16'h0000, 0);
        expect16("ret_wrap_addr", prg_addr, 16'h0000);
    endtask

    task automatic test_overflow();
        logic [15:0] ret_addr [17];
        do_reset();
        for (int k = 0; k < 17; k++) begin
            ret_addr[k] = (k == 0) ? 16'h0001 : 16'(16'h1000 + (k - 1) * 16 + 1);
            step(0, 0, 0, 0, 1, 0, 0, 0, 0, 10'h000, 16'(16'h1000 + k * 16), 1);
            if (k == 15) expect1("ovf_at_16", rs_overflow, 1'b0);
        end
        expect1("ovf_at_17", rs_overflow, 1'b1);
        for (int j = 0; j < 17; j++) begin
            step(0, 0, 0, 0, 0, 1, 0, 0, 0, 10'h000, 16'h0000, 0);
            expect16("ret_order", prg_addr, (j < 16) ? ret_addr[16 - j] : ret_addr[16]);
            if (j == 15) expect1("unf_at_16", rs_underflow, 1'b0);
        end
        expect1("unf_at_17", rs_underflow, 1'b1);
        expect1("ovf_sticky", rs_overflow, 1'b1);
    endtask

    task automatic test_hazard_redirect();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, 10'h000, 16'hBEEF, 1);
        expect1("hazard_jmp_rst", obs_jr, 1'b1);
        expect16("hazard_jmp_addr", prg_addr, 16'hBEEF);
        expect1("flags_before_rst", rs_overflow & rs_underflow, 1'b1);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 10'h000, 16'h1234, 1);
        expect16("rst_mid_addr", prg_addr, 16'h0000);
        expect1("rst_mid_jmp_rst", obs_jr, 1'b0);
        expect1("rst_mid_flags", rs_overflow | rs_underflow, 1'b0);
        idle();
        expect16("after_rst_addr", prg_addr, 16'h0001);
    endtask

    task automatic test_back_to_back();
        int k;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 7));
            if (k == 2 && m_cnt == 0) k = 3;
            step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 k == 0, k == 3, k == 2, k == 1, 1'($urandom), 1'($urandom),
                 10'($urandom), 16'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_cache_miss();
        test_branch();
        test_call_ret();
        test_overflow();
        test_hazard_redirect();
        test_back_to_back();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
